// File: rtl/apb_store_pkg.sv
// Shared types and constants for the APB sample store: FSM encoding,
// register addresses and bus widths.
package apb_store_pkg;

   localparam int APB_AW = 8;
   localparam int APB_DW = 32;

   localparam logic [APB_AW-1:0] ADDR_STATUS = 8'hF0;
   localparam logic [APB_AW-1:0] ADDR_LAST   = 8'hF1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   // True for the read-only status registers that sit above the storage window.
   function automatic logic is_status_reg(input logic [APB_AW-1:0] addr);
      return (addr == ADDR_STATUS) || (addr == ADDR_LAST);
   endfunction

endpackage

// File: rtl/apb_store_ram.sv
// DEPTH x 32 storage array: synchronous write, combinational read,
// cleared by the asynchronous reset.
module apb_store_ram
   import apb_store_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              we_i,
   input  logic [IW-1:0]     waddr_i,
   input  logic [APB_DW-1:0] wdata_i,
   input  logic [IW-1:0]     raddr_i,
   output logic [APB_DW-1:0] rdata_o
);

   logic [APB_DW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Out-of-window indices are filtered by the caller's address decode.
   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_sample_store.sv
// APB3 completer holding the sampler's writes in a word array, with
// programmable wait states, error decode and read-only status registers.
module apb_sample_store
   import apb_store_pkg::*;
#(
   parameter int DEPTH       = 64,
   parameter int WAIT_STATES = 0
) (
   input  logic        pclk_i,
   input  logic        presetn_i,
   input  logic        psel_i,
   input  logic        penable_i,
   input  logic        pwrite_i,
   input  logic [7:0]  paddr_i,
   input  logic [31:0] pwdata_i,
   output logic        pready_o,
   output logic        pslverr_o,
   output logic [31:0] prdata_o,
   output logic        sample_vld_o,
   output logic [31:0] sample_data_o,
   output logic [15:0] wr_count_o
);

   localparam int         IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [8:0] DEPTH_L = 9'(DEPTH);
   localparam logic [2:0] WS_L    = 3'(WAIT_STATES);

   if (DEPTH < 1 || DEPTH > 240) begin : g_depth_chk
      $error("apb_sample_store: DEPTH must be in 1..240");
   end
   if (WAIT_STATES < 0 || WAIT_STATES > 7) begin : g_wait_chk
      $error("apb_sample_store: WAIT_STATES must be in 0..7");
   end

   state_e            state_q, state_d;
   logic [2:0]        wait_cnt_q, wait_cnt_d;
   logic [APB_AW-1:0] addr_q, addr_d;
   logic              write_q, write_d;
   logic [APB_DW-1:0] wdata_q, wdata_d;
   logic [APB_DW-1:0] rd_val_q, rd_val_d;
   logic              err_q, err_d;
   logic              pready_q, pready_d;
   logic              pslverr_q, pslverr_d;
   logic [APB_DW-1:0] prdata_q, prdata_d;
   logic              sample_vld_q, sample_vld_d;
   logic [APB_DW-1:0] sample_data_q, sample_data_d;
   logic [15:0]       wr_count_q, wr_count_d;
   logic [APB_AW-1:0] last_addr_q, last_addr_d;

   logic              ram_we;
   logic [APB_DW-1:0] ram_rdata;
   logic              is_mem;
   logic              setup_err;
   logic [APB_DW-1:0] setup_rdata;

   apb_store_ram #(.DEPTH(DEPTH), .IW(IW)) u_ram (
      .clk_i   (pclk_i),
      .rst_ni  (presetn_i),
      .we_i    (ram_we),
      .waddr_i (addr_q[IW-1:0]),
      .wdata_i (wdata_q),
      .raddr_i (paddr_i[IW-1:0]),
      .rdata_o (ram_rdata)
   );

   // Decode of the address presented in the setup phase; the read value is
   // captured here so the response reflects state at the setup edge.
   always_comb begin
      is_mem      = ({1'b0, paddr_i} < DEPTH_L);
      setup_err   = pwrite_i ? !is_mem : !(is_mem || is_status_reg(paddr_i));
      setup_rdata = '0;
      if (!pwrite_i) begin
         if (is_mem) begin
            setup_rdata = ram_rdata;
         end else if (paddr_i == ADDR_STATUS) begin
            setup_rdata = {16'h0, wr_count_q};
         end else if (paddr_i == ADDR_LAST) begin
            setup_rdata = {24'h0, last_addr_q};
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      addr_d        = addr_q;
      write_d       = write_q;
      wdata_d       = wdata_q;
      rd_val_d      = rd_val_q;
      err_d         = err_q;
      pready_d      = pready_q;
      pslverr_d     = pslverr_q;
      prdata_d      = prdata_q;
      sample_vld_d  = 1'b0;
      sample_data_d = sample_data_q;
      wr_count_d    = wr_count_q;
      last_addr_d   = last_addr_q;
      ram_we        = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (psel_i && !penable_i) begin
               addr_d     = paddr_i;
               write_d    = pwrite_i;
               wdata_d    = pwdata_i;
               rd_val_d   = setup_rdata;
               err_d      = setup_err;
               wait_cnt_d = '0;
               if (WAIT_STATES == 0) begin
                  pready_d  = 1'b1;
                  prdata_d  = setup_rdata;
                  pslverr_d = setup_err;
                  state_d   = RESP;
               end else begin
                  state_d = WAIT;
               end
            end
         end

         WAIT: begin
            if (!psel_i) begin
               pready_d = 1'b0;
               state_d  = IDLE;
            end else if (penable_i) begin
               wait_cnt_d = wait_cnt_q + 3'd1;
               if (wait_cnt_d == WS_L) begin
                  pready_d  = 1'b1;
                  prdata_d  = rd_val_q;
                  pslverr_d = err_q;
                  state_d   = RESP;
               end
            end
         end

         RESP: begin
            // Both a normal completion and an abort leave the response cleared.
            if (psel_i && penable_i && pready_q && write_q && !err_q) begin
               ram_we        = 1'b1;
               wr_count_d    = wr_count_q + 16'd1;
               last_addr_d   = addr_q;
               sample_data_d = wdata_q;
               sample_vld_d  = 1'b1;
            end
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            prdata_d  = '0;
            state_d   = IDLE;
         end

         default: begin
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            prdata_d  = '0;
            state_d   = IDLE;
         end
      endcase
   end

   always_ff @(posedge pclk_i or negedge presetn_i) begin
      if (!presetn_i) begin
         state_q       <= IDLE;
         wait_cnt_q    <= '0;
         addr_q        <= '0;
         write_q       <= 1'b0;
         wdata_q       <= '0;
         rd_val_q      <= '0;
         err_q         <= 1'b0;
         pready_q      <= 1'b0;
         pslverr_q     <= 1'b0;
         prdata_q      <= '0;
         sample_vld_q  <= 1'b0;
         sample_data_q <= '0;
         wr_count_q    <= '0;
         last_addr_q   <= '0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         addr_q        <= addr_d;
         write_q       <= write_d;
         wdata_q       <= wdata_d;
         rd_val_q      <= rd_val_d;
         err_q         <= err_d;
         pready_q      <= pready_d;
         pslverr_q     <= pslverr_d;
         prdata_q      <= prdata_d;
         sample_vld_q  <= sample_vld_d;
         sample_data_q <= sample_data_d;
         wr_count_q    <= wr_count_d;
         last_addr_q   <= last_addr_d;
      end
   end

   assign pready_o      = pready_q;
   assign pslverr_o     = pslverr_q;
   assign prdata_o      = prdata_q;
   assign sample_vld_o  = sample_vld_q;
   assign sample_data_o = sample_data_q;
   assign wr_count_o    = wr_count_q;

endmodule

// File: tb/tb_apb_sample_store.sv
// Directed bench for apb_sample_store: one instance with no wait states and
// one with two, sharing a single APB driver steered by sel2.
module tb_apb_sample_store;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        psel, penable, pwrite;
   logic [7:0]  paddr;
   logic [31:0] pwdata;
   logic        sel2;

   logic        pready0, pslverr0, vld0;
   logic [31:0] prdata0, sdata0;
   logic [15:0] wcnt0;
   logic        pready2, pslverr2, vld2;
   logic [31:0] prdata2, sdata2;
   logic [15:0] wcnt2;

   logic        cur_pready, cur_pslverr;
   logic [31:0] cur_prdata;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   apb_sample_store #(.DEPTH(64), .WAIT_STATES(0)) dut0 (
      .pclk_i        (clk),
      .presetn_i     (rst_n),
      .psel_i        (psel & !sel2),
      .penable_i     (penable),
      .pwrite_i      (pwrite),
      .paddr_i       (paddr),
      .pwdata_i      (pwdata),
      .pready_o      (pready0),
      .pslverr_o     (pslverr0),
      .prdata_o      (prdata0),
      .sample_vld_o  (vld0),
      .sample_data_o (sdata0),
      .wr_count_o    (wcnt0)
   );

   apb_sample_store #(.DEPTH(64), .WAIT_STATES(2)) dut2 (
      .pclk_i        (clk),
      .presetn_i     (rst_n),
      .psel_i        (psel & sel2),
      .penable_i     (penable),
      .pwrite_i      (pwrite),
      .paddr_i       (paddr),
      .pwdata_i      (pwdata),
      .pready_o      (pready2),
      .pslverr_o     (pslverr2),
      .prdata_o      (prdata2),
      .sample_vld_o  (vld2),
      .sample_data_o (sdata2),
      .wr_count_o    (wcnt2)
   );

   assign cur_pready  = sel2 ? pready2  : pready0;
   assign cur_pslverr = sel2 ? pslverr2 : pslverr0;
   assign cur_prdata  = sel2 ? prdata2  : prdata0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Entered #1 after an edge; leaves #1 after the commit edge with psel low,
   // so a following call starts a back-to-back setup phase.
   task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                           output logic [31:0] rdata, output logic err, output int acc);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
      @(posedge clk); #1;
      penable = 1'b1;
      acc = 1;
      while (!cur_pready && acc < 20) begin
         @(posedge clk); #1;
         acc++;
      end
      if (!cur_pready) check("pready_timeout", {31'b0, cur_pready}, 32'd1);
      rdata = cur_prdata;
      err   = cur_pslverr;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic do_write(input string tag, input logic [7:0] addr, input logic [31:0] data,
                           input logic exp_err);
      logic [31:0] rd;
      logic        err;
      int          acc;
      apb_xfer(1'b1, addr, data, rd, err, acc);
      check({tag, "_acc"}, 32'(acc), sel2 ? 32'd3 : 32'd1);
      check({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
   endtask

   task automatic do_read(input string tag, input logic [7:0] addr, input logic [31:0] exp_data,
                          input logic exp_err);
      logic [31:0] rd;
      logic        err;
      int          acc;
      apb_xfer(1'b0, addr, 32'h0, rd, err, acc);
      check({tag, "_acc"}, 32'(acc), sel2 ? 32'd3 : 32'd1);
      check({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
      check({tag, "_data"}, rd, exp_data);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; psel = 1'b0; penable = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_outs0", {pready0, pslverr0, vld0, 29'b0}, 32'h0);
      check("rst_prdata0", prdata0, 32'h0);
      check("rst_sdata0", sdata0, 32'h0);
      check("rst_wcnt0", {16'h0, wcnt0}, 32'h0);
      check("rst_outs2", {pready2, pslverr2, vld2, 29'b0}, 32'h0);
      check("rst_wcnt2", {16'h0, wcnt2}, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] exp_q[$];
      logic [31:0] d;

      sel2 = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
      psel = 1'b0; penable = 1'b0; rst_n = 1'b1;
      #2;
      do_reset();
      do_read("status_after_rst", 8'hF0, 32'h0, 1'b0);

      // Zero wait states: single write, strobe, readbacks.
      do_write("wr05", 8'h05, 32'hDEADBEEF, 1'b0);
      check("wr05_vld", {31'b0, vld0}, 32'd1);
      check("wr05_sdata", sdata0, 32'hDEADBEEF);
      check("wr05_wcnt", {16'h0, wcnt0}, 32'd1);
      @(posedge clk); #1;
      check("wr05_vld_drop", {31'b0, vld0}, 32'd0);
      check("wr05_sdata_hold", sdata0, 32'hDEADBEEF);
      do_read("rd05", 8'h05, 32'hDEADBEEF, 1'b0);
      do_read("rd_last", 8'hF1, 32'h05, 1'b0);

      // Error decode: out of window, write to read-only, read of a hole.
      do_write("wr80", 8'h80, 32'h11111111, 1'b1);
      check("wr80_wcnt", {16'h0, wcnt0}, 32'd1);
      check("wr80_vld", {31'b0, vld0}, 32'd0);
      do_write("wrF0", 8'hF0, 32'h0000FFFF, 1'b1);
      do_read("rd_status", 8'hF0, 32'd1, 1'b0);
      do_read("rd80", 8'h80, 32'h0, 1'b1);
      do_read("rd_last2", 8'hF1, 32'h05, 1'b0);

      // Two wait states.
      sel2 = 1'b1;
      do_write("ws2_wr03", 8'h03, 32'h12345678, 1'b0);
      check("ws2_wcnt", {16'h0, wcnt2}, 32'd1);
      do_read("ws2_rd03", 8'h03, 32'h12345678, 1'b0);

      // Protocol abort: psel dropped while waiting, no commit.
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h03; pwdata = 32'h0BAD0BAD;
      @(posedge clk); #1;
      penable = 1'b1;
      check("abort_pready", {31'b0, pready2}, 32'd0);
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
      check("abort_pready2", {31'b0, pready2}, 32'd0);
      check("abort_wcnt", {16'h0, wcnt2}, 32'd1);
      do_read("abort_rd03", 8'h03, 32'h12345678, 1'b0);
      sel2 = 1'b0;

      // Sampler-style stream into a freshly reset store.
      do_reset();
      for (int i = 0; i < 64; i++) begin
         d = {8'(i), 8'hA5, ~8'(i), 8'h5A};
         exp_q.push_back(d);
         do_write("stream_wr", 8'(i), d, 1'b0);
      end
      check("stream_wcnt", {16'h0, wcnt0}, 32'd64);
      for (int i = 0; i < 64; i++) begin
         d = exp_q.pop_front();
         do_read("stream_rd", 8'(i), d, 1'b0);
      end
      do_write("stream_wr40", 8'h40, 32'hCAFEF00D, 1'b1);
      check("stream_wcnt_hold", {16'h0, wcnt0}, 32'd64);
      do_read("stream_last", 8'hF1, 32'h3F, 1'b0);

      // Counter wrap.
      force dut0.wr_count_q = 16'hFFFF;
      @(posedge clk); #1;
      release dut0.wr_count_q;
      check("wrap_preload", {16'h0, wcnt0}, 32'h0000FFFF);
      do_write("wrap_wr", 8'h10, 32'h5555AAAA, 1'b0);
      check("wrap_wcnt", {16'h0, wcnt0}, 32'h0);
      do_read("wrap_status", 8'hF0, 32'h0, 1'b0);
      do_read("wrap_rd10", 8'h10, 32'h5555AAAA, 1'b0);

      // Reset asserted while waiting aborts the write.
      sel2 = 1'b1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h07; pwdata = 32'h77777777;
      @(posedge clk); #1;
      penable = 1'b1;
      rst_n = 1'b0;
      #1;
      check("rst_abort_pready", {31'b0, pready2}, 32'd0);
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_abort_wcnt", {16'h0, wcnt2}, 32'd0);
      check("rst_abort_vld", {31'b0, vld2}, 32'd0);
      do_read("rst_abort_rd07", 8'h07, 32'h0, 1'b0);
      do_write("after_abort_wr07", 8'h07, 32'h77777777, 1'b0);
      check("after_abort_wcnt", {16'h0, wcnt2}, 32'd1);
      check("after_abort_sdata", sdata2, 32'h77777777);
      do_read("after_abort_rd07", 8'h07, 32'h77777777, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
